// File: rtl/trisc_ctrl_if.sv
// -----------------------------------------------------------------------------
// trisc_ctrl_if
//   Bus bundle between the TRISC sequencer and its surroundings: the
//   synchronous instruction ROM, the accumulator datapath controls and the
//   request/acknowledge handshake for external B-path data.
//
//   Signals
//     imem_addr   instruction address (controller -> ROM)
//     imem_rdata  instruction {opcode[3:0], operand[N-1:0]}, one cycle latency
//     acc_q       current accumulator value (datapath -> controller)
//     acc_clear   clear accumulator
//     acc_load    load accumulator from mux
//     acc_inc     increment accumulator
//     acc_ab      mux select: 0 = immediate A, 1 = external B
//     acc_a       immediate operand for mux A input
//     data_req    request for external B data
//     data_ack    external data valid on B
//
//   Modports
//     master  controller side
//     slave   ROM / datapath / data-source side
// -----------------------------------------------------------------------------
interface trisc_ctrl_if #(
  parameter int N  = 4,
  parameter int AW = 4
);
  logic [AW-1:0] imem_addr;
  logic [N+3:0]  imem_rdata;
  logic [N-1:0]  acc_q;
  logic          acc_clear;
  logic          acc_load;
  logic          acc_inc;
  logic          acc_ab;
  logic [N-1:0]  acc_a;
  logic          data_req;
  logic          data_ack;

  modport master (
    output imem_addr,
    output acc_clear,
    output acc_load,
    output acc_inc,
    output acc_ab,
    output acc_a,
    output data_req,
    input  imem_rdata,
    input  acc_q,
    input  data_ack
  );

  modport slave (
    input  imem_addr,
    input  acc_clear,
    input  acc_load,
    input  acc_inc,
    input  acc_ab,
    input  acc_a,
    input  data_req,
    output imem_rdata,
    output acc_q,
    output data_ack
  );
endinterface

// File: rtl/trisc_ctrl.sv
// -----------------------------------------------------------------------------
// trisc_ctrl
//   Sequencer for the TRISC accumulator datapath. Fetches instructions from a
//   synchronous ROM, decodes them and drives the accumulator controls. Handles
//   external B-path loads through a req/ack handshake, jumps, conditional
//   jump on zero, repeat-increment and halt.
//
//   Parameters
//     N   accumulator/data width and instruction operand width
//     AW  program counter / instruction address width
//
//   Ports
//     clk      system clock, rising edge
//     rst_n    asynchronous active-low reset
//     run      start/enable, sampled only in FETCH
//     bus      trisc_ctrl_if.master (ROM, accumulator controls, B handshake)
//     halted   controller stopped
//     illegal  undefined opcode trapped (sticky)
//
//   Build option
//     TRISC_ILLEGAL_TRAP_EN  when defined, opcodes 8..14 set 'illegal' and halt;
//                            otherwise they execute as NOP and 'illegal' is 0.
//
//   Opcodes: 0 NOP, 1 CLR, 2 LDI, 3 LDB, 4 INC, 5 INCN, 6 JMP, 7 JZ, 15 HALT.
//   All controls are decoded from the registered state/ir, so they are
//   glitch-free with respect to the ROM, except acc_load in WAIT which follows
//   data_ack combinationally.
// -----------------------------------------------------------------------------
module trisc_ctrl #(
  parameter int N  = 4,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  trisc_ctrl_if.master bus,
  output logic         halted,
  output logic         illegal
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_CLR  = 4'd1;
  localparam logic [3:0] OP_LDI  = 4'd2;
  localparam logic [3:0] OP_LDB  = 4'd3;
  localparam logic [3:0] OP_INC  = 4'd4;
  localparam logic [3:0] OP_INCN = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_JZ   = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT,
    S_HALT
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n;
  logic [N+3:0]  ir, ir_n;
  logic [N-1:0]  rep_cnt, rep_n;

  // Field views of the freshly read ROM word and of the latched instruction.
  logic [3:0]    rd_op;
  logic [N-1:0]  rd_opnd;
  logic [3:0]    ir_op;
  logic [N-1:0]  ir_opnd;

  assign rd_op   = bus.imem_rdata[N+3:N];
  assign rd_opnd = bus.imem_rdata[N-1:0];
  assign ir_op   = ir[N+3:N];
  assign ir_opnd = ir[N-1:0];

  // The ROM address is the pc in every state; the ROM registers it on the edge
  // that leaves FETCH, so the word is valid during DECODE.
  assign bus.imem_addr = pc;

`ifdef TRISC_ILLEGAL_TRAP_EN
  logic illegal_q;
  logic trap_set;
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      pc      <= '0;
      ir      <= '0;
      rep_cnt <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      ir      <= ir_n;
      rep_cnt <= rep_n;
    end
  end

`ifdef TRISC_ILLEGAL_TRAP_EN
  // Sticky trap flag: only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (trap_set) begin
      illegal_q <= 1'b1;
    end
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    ir_n          = ir;
    rep_n         = rep_cnt;
    bus.acc_clear = 1'b0;
    bus.acc_load  = 1'b0;
    bus.acc_inc   = 1'b0;
    bus.acc_ab    = 1'b0;
    bus.acc_a     = '0;
    bus.data_req  = 1'b0;
    halted        = 1'b0;
`ifdef TRISC_ILLEGAL_TRAP_EN
    trap_set      = 1'b0;
`endif

    unique case (state)
      S_FETCH: begin
        if (run) begin
          state_n = S_DECODE;
        end
      end

      S_DECODE: begin
        ir_n    = bus.imem_rdata;
        pc_n    = pc + AW'(1);
        state_n = (rd_op == OP_LDB) ? S_WAIT : S_EXEC;
        // The repeat count is loaded here so EXEC can use it from its first
        // cycle without an extra setup cycle.
        if (rd_op == OP_INCN) begin
          rep_n = rd_opnd;
        end
      end

      S_EXEC: begin
        state_n = S_FETCH;
        case (ir_op)
          OP_NOP: ;
          OP_CLR: bus.acc_clear = 1'b1;
          OP_LDI: begin
            bus.acc_load = 1'b1;
            bus.acc_a    = ir_opnd;
          end
          OP_INC: bus.acc_inc = 1'b1;
          OP_INCN: begin
            if (rep_cnt != '0) begin
              bus.acc_inc = 1'b1;
              rep_n       = rep_cnt - N'(1);
            end
            // Stay while this is not the last increment, so operand k costs
            // exactly k EXEC cycles (and k=0 costs one idle cycle).
            if (rep_cnt > N'(1)) begin
              state_n = S_EXEC;
            end
          end
          OP_JMP: pc_n = AW'(ir_opnd);
          OP_JZ: begin
            if (bus.acc_q == '0) begin
              pc_n = AW'(ir_opnd);
            end
          end
          OP_HALT: state_n = S_HALT;
          default: begin
`ifdef TRISC_ILLEGAL_TRAP_EN
            if (ir_op >= 4'd8 && ir_op <= 4'd14) begin
              trap_set = 1'b1;
              state_n  = S_HALT;
            end
`endif
          end
        endcase
      end

      S_WAIT: begin
        bus.data_req = 1'b1;
        bus.acc_ab   = 1'b1;
        // Load in the same cycle the source presents valid B data.
        if (bus.data_ack) begin
          bus.acc_load = 1'b1;
          state_n      = S_FETCH;
        end
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_n = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_trisc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trisc_ctrl
//   Self-checking bench for trisc_ctrl. A small ROM and an accumulator around
//   the DUT form the environment. An instruction-level interpreter expands the
//   ROM program into the expected per-cycle trace of outputs (FETCH, DECODE,
//   execute cycles) and also carries the stimulus for each cycle (run,
//   data_ack, B data). Directed programs cover the listed scenarios, then
//   random programs are run.
// -----------------------------------------------------------------------------
module tb_trisc_ctrl;
  localparam int N  = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  logic halted;
  logic illegal;

  trisc_ctrl_if #(.N(N), .AW(AW)) bus ();

  trisc_ctrl #(.N(N), .AW(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .bus     (bus),
    .halted  (halted),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // ---------------- environment: ROM + accumulator ----------------
  logic [N+3:0] rom [16];
  logic [N-1:0] data_b;
  logic [N-1:0] acc;

  always_ff @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             acc <= '0;
    else if (bus.acc_clear) acc <= '0;
    else if (bus.acc_load)  acc <= bus.acc_ab ? data_b : bus.acc_a;
    else if (bus.acc_inc)   acc <= acc + 4'd1;
  end
  assign bus.acc_q = acc;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           run;
    bit           ack;
    logic [N-1:0] b;
    logic [AW-1:0] addr;
    bit clr, ld, inc, ab;
    logic [N-1:0] a;
    bit req, hlt, ill;
  } row_t;

  row_t tr[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [AW-1:0] addr, input logic clr, ld, inc, ab,
                                       input logic [N-1:0] a, input logic req, hlt, ill);
    return 32'({addr, clr, ld, inc, ab, a, req, hlt, ill});
  endfunction

  function automatic logic [31:0] obs_vec();
    return pack(bus.imem_addr, bus.acc_clear, bus.acc_load, bus.acc_inc, bus.acc_ab,
                bus.acc_a, bus.data_req, halted, illegal);
  endfunction

  // ---------------- reference model ----------------
  task automatic add(input int addr, input bit clr, ld, inc, ab, input int a,
                     input bit req, hlt, ill, input bit r, ack);
    row_t x;
    x.run  = r;
    x.ack  = ack;
    x.b    = N'($urandom_range(0, 15));
    x.addr = AW'(addr);
    x.clr  = clr; x.ld = ld; x.inc = inc; x.ab = ab;
    x.a    = N'(a);
    x.req  = req; x.hlt = hlt; x.ill = ill;
    tr.push_back(x);
  endtask

  function automatic bit noise();
    return bit'($urandom_range(0, 1));
  endfunction

  // Expands the current ROM program into an expected cycle trace.
  // idle_first: run=0 cycles before the first fetch; ldb_delay<0 means random.
  task automatic build(input int idle_first, input int ldb_delay, input int max_rows);
    int pc, acc_m, op, opnd, k, d;
    bit done, first;
    pc = 0; acc_m = 0; done = 0; first = 1;
    tr.delete();
    while (!done && tr.size() < max_rows) begin
      k = first ? idle_first : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      first = 0;
      repeat (k) add(pc, 0,0,0,0, 0, 0,0,0, 0, noise());
      add(pc, 0,0,0,0, 0, 0,0,0, 1, noise());             // FETCH
      add(pc, 0,0,0,0, 0, 0,0,0, noise(), noise());       // DECODE
      op   = int'(rom[pc][7:4]);
      opnd = int'(rom[pc][3:0]);
      pc   = (pc + 1) % 16;
      case (op)
        1: begin add(pc, 1,0,0,0, 0, 0,0,0, noise(), noise()); acc_m = 0; end
        2: begin add(pc, 0,1,0,0, opnd, 0,0,0, noise(), noise()); acc_m = opnd; end
        3: begin
          d = (ldb_delay >= 0) ? ldb_delay : int'($urandom_range(0, 4));
          repeat (d) add(pc, 0,0,0,1, 0, 1,0,0, noise(), 0);
          add(pc, 0,1,0,1, 0, 1,0,0, noise(), 1);
          acc_m = int'(tr[tr.size()-1].b);
        end
        4: begin add(pc, 0,0,1,0, 0, 0,0,0, noise(), noise()); acc_m = (acc_m + 1) % 16; end
        5: begin
          repeat ((opnd == 0) ? 1 : opnd) add(pc, 0,0,(opnd != 0),0, 0, 0,0,0, noise(), noise());
          acc_m = (acc_m + opnd) % 16;
        end
        6: begin add(pc, 0,0,0,0, 0, 0,0,0, noise(), noise()); pc = opnd; end
        7: begin add(pc, 0,0,0,0, 0, 0,0,0, noise(), noise()); if (acc_m == 0) pc = opnd; end
        15: begin
          add(pc, 0,0,0,0, 0, 0,0,0, noise(), noise());
          repeat (4) add(pc, 0,0,0,0, 0, 0,1,0, noise(), noise());
          done = 1;
        end
        default: begin
          add(pc, 0,0,0,0, 0, 0,0,0, noise(), noise());
`ifdef TRISC_ILLEGAL_TRAP_EN
          if (op >= 8 && op <= 14) begin
            repeat (4) add(pc, 0,0,0,0, 0, 0,1,1, noise(), noise());
            done = 1;
          end
`endif
        end
      endcase
    end
  endtask

  // Plays rows [0, upto) against the DUT; entry and exit at posedge+1.
  task automatic run_trace(input string name, input int upto);
    for (int i = 0; i < upto && i < tr.size(); i++) begin
      run          = tr[i].run;
      bus.data_ack = tr[i].ack;
      data_b       = tr[i].b;
      @(negedge clk);
      check($sformatf("%s cyc %0d", name, i), obs_vec(),
            pack(tr[i].addr, tr[i].clr, tr[i].ld, tr[i].inc, tr[i].ab,
                 tr[i].a, tr[i].req, tr[i].hlt, tr[i].ill));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; bus.data_ack = 1'b0; data_b = '0;
    @(negedge clk);
    check("reset_outputs", obs_vec(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = '0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bus.data_ack = 1'b0;
    data_b = '0;
    clear_rom();

    // LDI 5, INC, HALT
    rom[0] = 8'h25; rom[1] = 8'h40; rom[2] = 8'hF0;
    do_reset();
    build(0, -1, 200);
    run_trace("ldi_inc_halt", tr.size());
    check("p1_acc", 32'(acc), 32'd6);
    check("p1_pc", 32'(bus.imem_addr), 32'd3);
    check("p1_halted", 32'(halted), 32'd1);

    // INCN 3, INCN 0, HALT
    clear_rom();
    rom[0] = 8'h53; rom[1] = 8'h50; rom[2] = 8'hF0;
    do_reset();
    build(0, -1, 200);
    run_trace("incn", tr.size());
    check("p2_acc", 32'(acc), 32'd3);

    // LDB with ack after 4 waiting cycles
    clear_rom();
    rom[0] = 8'h30; rom[1] = 8'hF0;
    do_reset();
    build(0, 4, 200);
    run_trace("ldb", tr.size());

    // JZ taken / not taken, JMP 0 from address 15 (loops; trace is capped)
    clear_rom();
    rom[0] = 8'h10; rom[1] = 8'h79; rom[9] = 8'h23; rom[10] = 8'h70;
    rom[11] = 8'h6F; rom[15] = 8'h60;
    do_reset();
    build(0, -1, 60);
    run_trace("jz_jmp", tr.size());

    // run=0 for 5 cycles, then sequential wrap 15 -> 0 without a jump
    clear_rom();
    rom[0] = 8'h6E; rom[14] = 8'h40; rom[15] = 8'h00;
    do_reset();
    build(5, -1, 40);
    run_trace("idle_wrap", tr.size());

    // Reset in the middle of INCN 7
    clear_rom();
    rom[0] = 8'h57; rom[1] = 8'hF0;
    do_reset();
    build(0, -1, 200);
    run_trace("incn7_pre", 4);
    #2;
    check("incn7_inc_before_reset", 32'(bus.acc_inc), 32'd1);
    rst_n = 1'b0;
    #1;
    check("incn7_reset_inc", 32'(bus.acc_inc), 32'd0);
    check("incn7_reset_outputs", obs_vec(), 32'd0);
    run = 1'b0; bus.data_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("incn7_idle_after_reset", obs_vec(), 32'd0);
    end
    @(posedge clk);
    #1;
    build(0, -1, 200);
    run_trace("incn7_rerun", tr.size());

    // Undefined opcode 9
    clear_rom();
    rom[0] = 8'h90; rom[1] = 8'h21; rom[2] = 8'hF0;
    do_reset();
    build(0, -1, 200);
    run_trace("opcode9", tr.size());

    // Random programs
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 16; i++) begin
        int r;
        logic [3:0] op;
        r = int'($urandom_range(0, 11));
        if (r <= 7)       op = 4'(r);
        else if (r == 8)  op = 4'd15;
        else if (r == 9)  op = 4'($urandom_range(8, 14));
        else              op = 4'd5;
        rom[i] = {op, 4'($urandom_range(0, 15))};
      end
      do_reset();
      build(int'($urandom_range(0, 3)), -1, 150);
      run_trace($sformatf("rand%0d", p), tr.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
